// File: rtl/instr_mem_loadable.sv
// Runtime-loadable instruction memory: post-reset clear sweep, streaming load
// port and a one-cycle registered fetch port with range/alignment fault flag.
module instr_mem_loadable #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 5,
  parameter bit                    BYTE_ADDR  = 1'b0,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  FetchEn,
  input  logic [31:0]           Address,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  DataValid,
  output logic                  Fault,
  output logic                  Ready,
  input  logic                  LoadStart,
  input  logic [ADDR_WIDTH-1:0] LoadBase,
  input  logic                  LoadValid,
  input  logic [DATA_WIDTH-1:0] LoadData,
  input  logic                  LoadLast,
  output logic                  LoadDone,
  output logic                  LoadOverflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_READY = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t                  state;
  // Extra MSB marks a load pointer that has run past DEPTH-1.
  logic [PTR_W-1:0]        ptr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [31:0]             idx_full;
  logic [ADDR_WIDTH-1:0]   fetch_idx;
  logic                    out_of_range;
  logic                    misaligned;
  logic                    fetch_fault;

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  // Fetch address decode: word index plus fault qualification.
  always_comb begin
    idx_full     = BYTE_ADDR ? {2'b00, Address[31:2]} : Address;
    fetch_idx    = idx_full[ADDR_WIDTH-1:0];
    out_of_range = (idx_full >> ADDR_WIDTH) != 32'd0;
    misaligned   = BYTE_ADDR && (Address[1:0] != 2'b00);
    fetch_fault  = out_of_range | misaligned;
  end

  // Single write port shared by the clear sweep and the load stream.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ptr[ADDR_WIDTH-1:0];
    mem_wdata = NOP_WORD;
    if (Reset_n) begin
      case (state)
        ST_CLEAR: mem_we = 1'b1;
        ST_LOAD: begin
          if (!LoadStart && LoadValid && !ptr[ADDR_WIDTH]) begin
            mem_we    = 1'b1;
            mem_wdata = LoadData;
          end
        end
        default: mem_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Control FSM with registered status and fetch outputs.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state        <= ST_CLEAR;
      ptr          <= '0;
      ReadData     <= '0;
      DataValid    <= 1'b0;
      Fault        <= 1'b0;
      Ready        <= 1'b0;
      LoadDone     <= 1'b0;
      LoadOverflow <= 1'b0;
    end else begin
      DataValid <= 1'b0;
      Fault     <= 1'b0;
      Ready     <= 1'b0;
      LoadDone  <= 1'b0;
      case (state)
        ST_CLEAR: begin
          if (ptr == PTR_W'(DEPTH - 1)) begin
            state <= ST_READY;
            ptr   <= '0;
          end else begin
            ptr <= ptr + PTR_W'(1);
          end
        end
        ST_READY: begin
          if (FetchEn) begin
            DataValid <= 1'b1;
            Fault     <= fetch_fault;
            ReadData  <= fetch_fault ? NOP_WORD : mem[fetch_idx];
          end
          if (LoadStart) begin
            ptr          <= {1'b0, LoadBase};
            LoadOverflow <= 1'b0;
            state        <= ST_LOAD;
          end else begin
            Ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (LoadStart) begin
            ptr          <= {1'b0, LoadBase};
            LoadOverflow <= 1'b0;
          end else if (LoadValid) begin
            if (ptr[ADDR_WIDTH]) begin
              LoadOverflow <= 1'b1;
            end else begin
              ptr <= ptr + PTR_W'(1);
            end
            if (LoadLast) begin
              LoadDone <= 1'b1;
              state    <= ST_READY;
            end
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Self-checking bench for instr_mem_loadable: directed vectors, load sessions
// and random traffic against an array-based reference model.
module tb_instr_mem_loadable;

  localparam int unsigned DEPTH = 32;

  logic        Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Word-addressed instance (defaults)
  logic        reset_n, fetch_en, data_valid, fault, ready;
  logic [31:0] address, read_data, load_data;
  logic        load_start, load_valid, load_last, load_done, load_overflow;
  logic [4:0]  load_base;

  // Byte-addressed instance
  logic        b_reset_n, b_fetch_en, b_data_valid, b_fault, b_ready;
  logic [31:0] b_address, b_read_data, b_load_data;
  logic        b_load_start, b_load_valid, b_load_last, b_load_done, b_load_overflow;
  logic [4:0]  b_load_base;

  instr_mem_loadable u_dut (
    .Clk(Clk), .Reset_n(reset_n), .FetchEn(fetch_en), .Address(address),
    .ReadData(read_data), .DataValid(data_valid), .Fault(fault), .Ready(ready),
    .LoadStart(load_start), .LoadBase(load_base), .LoadValid(load_valid),
    .LoadData(load_data), .LoadLast(load_last), .LoadDone(load_done),
    .LoadOverflow(load_overflow)
  );

  instr_mem_loadable #(.BYTE_ADDR(1'b1), .NOP_WORD(32'h0000_0013)) u_dut_b (
    .Clk(Clk), .Reset_n(b_reset_n), .FetchEn(b_fetch_en), .Address(b_address),
    .ReadData(b_read_data), .DataValid(b_data_valid), .Fault(b_fault), .Ready(b_ready),
    .LoadStart(b_load_start), .LoadBase(b_load_base), .LoadValid(b_load_valid),
    .LoadData(b_load_data), .LoadLast(b_load_last), .LoadDone(b_load_done),
    .LoadOverflow(b_load_overflow)
  );

  int checks = 0;
  int passes = 0;

  logic [31:0] model [DEPTH];
  logic        model_ovf;
  logic [31:0] sess_words [8];

  typedef struct {
    logic        en;
    logic [31:0] addr;
    logic        valid;
    logic        flt;
    logic [31:0] data;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] addr, input string name);
    logic        ef;
    logic [31:0] ed;
    ef = (addr >= DEPTH);
    ed = ef ? 32'h0 : model[addr[4:0]];
    fetch_en = 1'b1;
    address  = addr;
    step();
    fetch_en = 1'b0;
    check({name, " valid"}, data_valid, 1);
    check({name, " fault"}, fault, 32'(ef));
    check({name, " data"},  read_data, ed);
  endtask

  // Drives one load session of n words from sess_words, updating the model.
  task automatic load_session(input logic [4:0] base, input int n,
                              input bit fetch_at_start, input logic [31:0] faddr);
    int          ptr;
    logic        ef;
    logic [31:0] ed;
    ef = (faddr >= DEPTH);
    ed = ef ? 32'h0 : model[faddr[4:0]];
    load_start = 1'b1;
    load_base  = base;
    fetch_en   = fetch_at_start;
    address    = faddr;
    step();
    load_start = 1'b0;
    fetch_en   = 1'b0;
    check("start ready low", ready, 0);
    if (fetch_at_start) begin
      check("start fetch valid", data_valid, 1);
      check("start fetch data", read_data, ed);
    end
    model_ovf = 1'b0;
    ptr = int'(base);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < 2 && $urandom_range(0, 3) == 0; g++) begin
        load_valid = 1'b0;
        fetch_en   = 1'($urandom);
        address    = 32'($urandom_range(0, 40));
        step();
        check("gap no valid", data_valid, 0);
        check("gap no done", load_done, 0);
      end
      load_valid = 1'b1;
      load_data  = sess_words[i];
      load_last  = (i == n - 1);
      fetch_en   = 1'($urandom);
      address    = 32'($urandom_range(0, 40));
      step();
      if (ptr < int'(DEPTH)) begin
        model[ptr] = sess_words[i];
        ptr++;
      end else begin
        model_ovf = 1'b1;
      end
      check("load dropped fetch", data_valid, 0);
      check("load done", load_done, 32'(i == n - 1));
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    fetch_en   = 1'b0;
    check("overflow", load_overflow, 32'(model_ovf));
    step();
    check("done one pulse", load_done, 0);
    check("ready after load", ready, 1);
  endtask

  task automatic b_fetch(input logic [31:0] addr, input logic ef, input logic [31:0] ed);
    b_fetch_en = 1'b1;
    b_address  = addr;
    step();
    b_fetch_en = 1'b0;
    check("byte valid", b_data_valid, 1);
    check("byte fault", b_fault, 32'(ef));
    check("byte data",  b_read_data, ed);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  bad;
    reset_n = 1'b0; fetch_en = 1'b0; address = '0; load_start = 1'b0;
    load_base = '0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    b_reset_n = 1'b0; b_fetch_en = 1'b0; b_address = '0; b_load_start = 1'b0;
    b_load_base = '0; b_load_valid = 1'b0; b_load_data = '0; b_load_last = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'h0;
    model_ovf = 1'b0;

    vecs[0] = '{1'b1, 32'd0,          1'b1, 1'b0, 32'h2001_0001};
    vecs[1] = '{1'b1, 32'd1,          1'b1, 1'b0, 32'h2014_DEAD};
    vecs[2] = '{1'b1, 32'd2,          1'b1, 1'b0, 32'hAC34_0000};
    vecs[3] = '{1'b0, 32'd5,          1'b0, 1'b0, 32'hAC34_0000};
    vecs[4] = '{1'b1, 32'd32,         1'b1, 1'b1, 32'h0000_0000};
    vecs[5] = '{1'b1, 32'hFFFF_0000,  1'b1, 1'b1, 32'h0000_0000};
    vecs[6] = '{1'b1, 32'd7,          1'b1, 1'b0, 32'h0000_0000};
    vecs[7] = '{1'b1, 32'd31,         1'b1, 1'b0, 32'h0000_0000};

    // Reset values
    repeat (3) step();
    check("rst ready", ready, 0);
    check("rst valid", data_valid, 0);
    check("rst fault", fault, 0);
    check("rst data", read_data, 0);
    check("rst done", load_done, 0);
    check("rst ovf", load_overflow, 0);

    // Clear sweep; fetch/load inputs must be ignored meanwhile
    reset_n = 1'b1; b_reset_n = 1'b1;
    fetch_en = 1'b1; address = 32'd3; load_start = 1'b1; load_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (ready || data_valid || load_done) bad = 1'b1;
    end
    fetch_en = 1'b0; load_start = 1'b0; load_valid = 1'b0;
    check("clear quiet 32 cycles", 32'(bad), 0);
    step();
    check("ready on 33rd", ready, 1);
    do_fetch(32'd7, "post-clear fetch 7");

    // Program load then back-to-back table fetches
    sess_words[0] = 32'h2001_0001;
    sess_words[1] = 32'h2014_DEAD;
    sess_words[2] = 32'hAC34_0000;
    load_session(5'd0, 3, 1'b0, 32'd0);
    for (int i = 0; i < 8; i++) begin
      fetch_en = vecs[i].en;
      address  = vecs[i].addr;
      step();
      check($sformatf("vec%0d valid", i), data_valid, 32'(vecs[i].valid));
      check($sformatf("vec%0d fault", i), fault, 32'(vecs[i].flt));
      check($sformatf("vec%0d data", i), read_data, vecs[i].data);
    end
    fetch_en = 1'b0;

    // Overflow at top of memory, with a fetch served alongside LoadStart
    sess_words[0] = 32'hA000_0030;
    sess_words[1] = 32'hA000_0031;
    sess_words[2] = 32'hA000_0032;
    sess_words[3] = 32'hA000_0033;
    load_session(5'd30, 4, 1'b1, 32'd1);
    check("ovf sticky set", load_overflow, 1);
    do_fetch(32'd30, "ovf slot30");
    do_fetch(32'd31, "ovf slot31");
    do_fetch(32'd0, "no wrap slot0");

    // Restart clears overflow; same-cycle LoadValid on restart is ignored
    load_start = 1'b1; load_base = 5'd10;
    step();
    check("restart ovf clear", load_overflow, 0);
    load_base = 5'd12; load_valid = 1'b1; load_data = 32'h0000_0055;
    step();
    load_start = 1'b0; load_data = 32'h0000_0066; load_last = 1'b1;
    step();
    model[12] = 32'h0000_0066;
    check("restart done", load_done, 1);
    load_valid = 1'b0; load_last = 1'b0;
    step();
    check("restart ready", ready, 1);
    do_fetch(32'd10, "restart slot10");
    do_fetch(32'd12, "restart slot12");
    do_fetch(32'd13, "restart slot13");

    // Random traffic against the model
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        n = $urandom_range(1, 6);
        for (int k = 0; k < n; k++) sess_words[k] = $urandom;
        load_session(5'($urandom_range(0, 31)), n, 1'($urandom), 32'($urandom_range(0, 40)));
      end else if ($urandom_range(0, 7) == 0) begin
        do_fetch($urandom, "rand far fetch");
      end else begin
        do_fetch(32'($urandom_range(0, 40)), "rand fetch");
      end
    end

    // Reset in the middle of a session that has already overflowed
    load_start = 1'b1; load_base = 5'd31;
    step();
    load_start = 1'b0; load_valid = 1'b1; load_data = 32'h1111_1111;
    step();
    load_data = 32'h2222_2222;
    step();
    check("mid-load ovf", load_overflow, 1);
    reset_n = 1'b0; load_last = 1'b1; load_data = 32'h3333_3333;
    step();
    check("mid-load rst ovf", load_overflow, 0);
    check("mid-load rst done", load_done, 0);
    check("mid-load rst ready", ready, 0);
    reset_n = 1'b1; load_valid = 1'b0; load_last = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'h0;
    n = 0; bad = 1'b0;
    while (!ready && n < 100) begin
      step();
      n++;
      if (load_done) bad = 1'b1;
    end
    check("reclear cycles", 32'(n), 33);
    check("reclear no done", 32'(bad), 0);
    for (int i = 0; i < int'(DEPTH); i++) do_fetch(32'(i), "reclear slot");
    check("reclear ovf", load_overflow, 0);

    // Byte-addressed build
    check("byte ready", b_ready, 1);
    b_load_start = 1'b1; b_load_base = 5'd4;
    step();
    b_load_start = 1'b0; b_load_valid = 1'b1; b_load_data = 32'h1234_5678; b_load_last = 1'b1;
    step();
    check("byte done", b_load_done, 1);
    b_load_valid = 1'b0; b_load_last = 1'b0;
    step();
    check("byte ready after", b_ready, 1);
    b_fetch(32'd16,  1'b0, 32'h1234_5678);
    b_fetch(32'd17,  1'b1, 32'h0000_0013);
    b_fetch(32'd0,   1'b0, 32'h0000_0013);
    b_fetch(32'd124, 1'b0, 32'h0000_0013);
    b_fetch(32'd128, 1'b1, 32'h0000_0013);
    b_fetch(32'd18,  1'b1, 32'h0000_0013);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
